// File: rtl/druaga_load_ctrl.sv
// druaga_load_ctrl: routes the HPS download stream into the core ROM, title and DIP latches, and owns core reset.
// Define LOAD_CHECKSUM_EN to build the additive ROM checksum; otherwise checksum reads 8'h00.
module druaga_load_ctrl #(
  parameter int ROM_AW   = 17,
  parameter int ROM_SIZE = 81920,
  parameter int RST_HOLD = 256
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              user_rst,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic [7:0]        ioctl_index,
  output logic              rom_we,
  output logic [ROM_AW-1:0] rom_addr,
  output logic [7:0]        rom_dout,
  output logic [3:0]        tno,
  output logic [23:0]       dsw,
  output logic              core_reset,
  output logic              loaded,
  output logic              overflow,
  output logic [7:0]        checksum
);
  localparam int HW = RST_HOLD > 1 ? $clog2(RST_HOLD) : 1;
  localparam logic [ROM_AW:0] CSZ = (ROM_AW+1)'(ROM_SIZE);
  localparam logic [HW-1:0] HEND = HW'(RST_HOLD-1);
  typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;
  state_t r_state, w_next;
  logic [ROM_AW:0] r_cnt, w_base;
  logic [HW-1:0] r_hold;
  logic r_idx0, r_loaded, r_ovf, r_crst, r_we;
  logic [ROM_AW-1:0] r_addr;
  logic [7:0] r_dout, r_sw0, r_sw1, r_sw2;
  logic [3:0] r_tno;
  logic w_wr, w_in, w_enter, w_clr, w_exit, w_ok, w_rom, w_sw;
  assign w_wr    = ioctl_wr & ioctl_download;
  assign w_in    = ioctl_addr < 25'(ROM_SIZE);
  assign w_enter = r_state != LOAD && w_next == LOAD;
  assign w_clr   = w_enter && ioctl_index == 8'd0;
  assign w_exit  = r_state == LOAD && !ioctl_download;
  // A non-ROM download keeps whatever validity the ROM image already had
  assign w_ok    = r_idx0 ? r_cnt >= CSZ : r_loaded;
  assign w_rom   = w_wr && ioctl_index == 8'd0 && w_in;
  assign w_sw    = w_wr && ioctl_index == 8'd254 && ioctl_addr[24:3] == 22'd0;
  assign w_base  = w_clr ? '0 : r_cnt;
  always_comb begin
    w_next = ioctl_download ? LOAD :
             r_state == LOAD ? (w_ok ? HOLD : IDLE) :
             r_state == HOLD && r_hold == HEND ? RUN : r_state;
  end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_hold   <= '0;
      r_idx0   <= 1'b0;
      r_loaded <= 1'b0;
      r_ovf    <= 1'b0;
      r_crst   <= 1'b1;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_dout   <= '0;
      r_tno    <= '0;
      r_sw0    <= '0;
      r_sw1    <= '0;
      r_sw2    <= '0;
    end else begin
      r_state <= w_next;
      r_hold  <= r_state == HOLD ? r_hold + 1'b1 : '0;
      r_crst  <= user_rst | (r_state != RUN);
      r_we    <= w_rom;
      r_cnt   <= w_base + (ROM_AW+1)'(w_rom && !(&w_base));
      if (w_enter) r_idx0 <= ioctl_index == 8'd0;
      if (w_clr) r_loaded <= 1'b0;
      if (w_exit) r_loaded <= w_ok;
      if (w_clr) r_ovf <= 1'b0;
      if (w_wr && ioctl_index == 8'd0 && !w_in) r_ovf <= 1'b1;
      if (w_rom) begin
        r_addr <= ioctl_addr[ROM_AW-1:0];
        r_dout <= ioctl_dout;
      end
      if (w_wr && ioctl_index == 8'd1) r_tno <= ioctl_dout[3:0];
      r_sw0 <= w_sw && ioctl_addr[2:0] == 3'd0 ? ioctl_dout : r_sw0;
      r_sw1 <= w_sw && ioctl_addr[2:0] == 3'd1 ? ioctl_dout : r_sw1;
      r_sw2 <= w_sw && ioctl_addr[2:0] == 3'd2 ? ioctl_dout : r_sw2;
    end
  end
`ifdef LOAD_CHECKSUM_EN
  logic [7:0] r_sum;
  always_ff @(posedge clk_sys) begin
    if (reset) r_sum <= '0;
    else r_sum <= (w_clr ? 8'h00 : r_sum) + (w_rom ? ioctl_dout : 8'h00);
  end
  assign checksum = r_sum;
`else
  assign checksum = 8'h00;
`endif
  assign rom_we     = r_we;
  assign rom_addr   = r_addr;
  assign rom_dout   = r_dout;
  assign tno        = r_tno;
  assign core_reset = r_crst;
  assign loaded     = r_loaded;
  assign overflow   = r_ovf;
  assign dsw = (r_tno == 4'd1 || r_tno == 4'd3) ? {r_sw1[3:0], r_sw2[3:0], r_sw1, r_sw0} :
               r_tno == 4'd2 ? {r_sw2[3:0], r_sw2[3:0], r_sw1, r_sw0} : {r_sw2, r_sw1, r_sw0};
endmodule

// File: tb/tb_druaga_load_ctrl.sv
// tb_druaga_load_ctrl: directed download scenarios checked every cycle against a transaction-level model.
module tb_druaga_load_ctrl;
  localparam int AW = 12;
  localparam int SZ = 3000;
  localparam int RH = 20;
  logic clk_sys = 0, reset = 1, user_rst = 0, ioctl_download = 0, ioctl_wr = 0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0] ioctl_dout = '0, ioctl_index = '0;
  logic rom_we, core_reset, loaded, overflow;
  logic [AW-1:0] rom_addr;
  logic [7:0] rom_dout, checksum;
  logic [3:0] tno;
  logic [23:0] dsw;
  int n_chk = 0, n_fail = 0, pulses = 0, k;
  bit chk_on = 0;

  druaga_load_ctrl #(.ROM_AW(AW), .ROM_SIZE(SZ), .RST_HOLD(RH)) dut (
    .clk_sys(clk_sys), .reset(reset), .user_rst(user_rst), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index),
    .rom_we(rom_we), .rom_addr(rom_addr), .rom_dout(rom_dout), .tno(tno), .dsw(dsw),
    .core_reset(core_reset), .loaded(loaded), .overflow(overflow), .checksum(checksum));

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] f_dsw(input logic [3:0] t, input logic [7:0] s0, s1, s2);
    if (t == 1 || t == 3) return {s1[3:0], s2[3:0], s1, s0};
    if (t == 2) return {s2[3:0], s2[3:0], s1, s0};
    return {s2, s1, s0};
  endfunction

  // model: edge-timestamped view of the download protocol
  int edge_n = 0, cnt = 0, run_edge = 0;
  bit in_load = 0, idx0 = 0, run_ok = 0, prev_run = 0;
  bit e_we = 0, e_loaded = 0, e_ovf = 0, e_crst = 1;
  logic [AW-1:0] e_addr = '0;
  logic [7:0] e_dout = '0, e_sum = '0;
  logic [3:0] e_tno = '0;
  logic [7:0] e_sw [3] = '{8'h0, 8'h0, 8'h0};

  always @(posedge clk_sys) begin
    edge_n++;
    if (reset) begin
      cnt = 0; in_load = 0; idx0 = 0; run_ok = 0; prev_run = 0;
      e_we = 0; e_loaded = 0; e_ovf = 0; e_crst = 1; e_sum = 0; e_tno = 0;
      e_sw[0] = 0; e_sw[1] = 0; e_sw[2] = 0;
    end else begin
      e_crst = user_rst || !prev_run;
      e_we = 0;
      if (ioctl_download && !in_load) begin
        in_load = 1; run_ok = 0; idx0 = (ioctl_index == 0);
        if (idx0) begin cnt = 0; e_loaded = 0; e_ovf = 0; e_sum = 0; end
      end
      if (ioctl_download && ioctl_wr) begin
        if (ioctl_index == 0) begin
          if (ioctl_addr < SZ) begin
            e_we = 1; e_addr = ioctl_addr[AW-1:0]; e_dout = ioctl_dout;
            if (cnt < 2 ** (AW + 1) - 1) cnt++;
            e_sum = e_sum + ioctl_dout;
          end else e_ovf = 1;
        end else if (ioctl_index == 1) e_tno = ioctl_dout[3:0];
        else if (ioctl_index == 254 && ioctl_addr < 3) e_sw[ioctl_addr[1:0]] = ioctl_dout;
      end
      if (!ioctl_download && in_load) begin
        in_load = 0;
        if (idx0) e_loaded = (cnt >= SZ);
        if (e_loaded) begin run_ok = 1; run_edge = edge_n + RH; end
      end
      prev_run = run_ok && edge_n >= run_edge;
    end
  end

  always @(negedge clk_sys) begin
    if (chk_on) begin
      chk("rom_we", 32'(rom_we), 32'(e_we));
      if (e_we) begin
        chk("rom_addr", 32'(rom_addr), 32'(e_addr));
        chk("rom_dout", 32'(rom_dout), 32'(e_dout));
      end
      chk("tno", 32'(tno), 32'(e_tno));
      chk("dsw", 32'(dsw), 32'(f_dsw(e_tno, e_sw[0], e_sw[1], e_sw[2])));
      chk("core_reset", 32'(core_reset), 32'(e_crst));
      chk("loaded", 32'(loaded), 32'(e_loaded));
      chk("overflow", 32'(overflow), 32'(e_ovf));
`ifdef LOAD_CHECKSUM_EN
      chk("checksum", 32'(checksum), 32'(e_sum));
`else
      chk("checksum", 32'(checksum), 32'h0);
`endif
      if (rom_we === 1'b1) pulses++;
    end
  end

  task automatic tick();
    @(posedge clk_sys); #1;
  endtask

  task automatic load_seq(input logic [7:0] idx, input int n, input int base, input int rst_at);
    ioctl_index = idx; ioctl_download = 1; tick();
    for (int i = 0; i < n; i++) begin
      ioctl_wr = 1; ioctl_addr = 25'(base + i); ioctl_dout = 8'(i) ^ 8'h5A; reset = (i == rst_at);
      tick();
    end
    reset = 0; ioctl_wr = 0; ioctl_download = 0;
  endtask

  task automatic dl_bytes(input logic [7:0] idx, input int n, input logic [23:0] d);
    ioctl_index = idx; ioctl_download = 1; tick();
    for (int i = 0; i < n; i++) begin
      ioctl_wr = 1; ioctl_addr = 25'(i); ioctl_dout = d[8*i +: 8]; tick();
    end
    ioctl_wr = 0; ioctl_download = 0;
  endtask

  initial begin
    repeat (3) tick();
    chk_on = 1;
    tick();
    reset = 0;
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_loaded", 32'(loaded), 32'd0);
    chk("rst_dsw", 32'(dsw), 32'd0);
    chk("rst_rom_we", 32'(rom_we), 32'd0);
    chk("rst_checksum", 32'(checksum), 32'd0);
    tick();
    // short image never leaves reset
    load_seq(8'd0, 1000, 0, -1);
    repeat (RH + 10) tick();
    chk("short_loaded", 32'(loaded), 32'd0);
    chk("short_core_reset", 32'(core_reset), 32'd1);
    // out-of-range ROM byte
    pulses = 0;
    load_seq(8'd0, 1, SZ, -1);
    repeat (3) tick();
    chk("ovf_pulses", 32'(pulses), 32'd0);
    chk("ovf_set", 32'(overflow), 32'd1);
    // full image
    pulses = 0;
    load_seq(8'd0, SZ, 0, -1);
    k = 0;
    while (core_reset !== 1'b0 && k < 200) begin tick(); k++; end
    chk("full_crst_fall", 32'(k), 32'(RH + 2));
    chk("full_pulses", 32'(pulses), 32'(SZ));
    chk("full_loaded", 32'(loaded), 32'd1);
    chk("full_ovf_clr", 32'(overflow), 32'd0);
    // title and DIP downloads on top of a valid ROM
    ioctl_index = 8'd1; ioctl_download = 1; tick();
    chk("rise_crst_1", 32'(core_reset), 32'd0);
    tick();
    chk("rise_crst_2", 32'(core_reset), 32'd1);
    ioctl_wr = 1; ioctl_addr = '0; ioctl_dout = 8'h02; tick();
    ioctl_wr = 0; ioctl_download = 0; tick();
    dl_bytes(8'd254, 3, 24'h7E3CA5);
    repeat (RH + 5) tick();
    chk("dip_tno", 32'(tno), 32'd2);
    chk("dip_dsw2", 32'(dsw), 32'hEE3CA5);
    chk("dip_loaded", 32'(loaded), 32'd1);
    chk("dip_run", 32'(core_reset), 32'd0);
    dl_bytes(8'd1, 1, 24'h000003);
    tick();
    chk("dip_dsw3", 32'(dsw), 32'hCE3CA5);
    dl_bytes(8'd1, 1, 24'h000007);
    repeat (RH + 5) tick();
    chk("dip_dsw7", 32'(dsw), 32'h7E3CA5);
    chk("dip_run2", 32'(core_reset), 32'd0);
    // user reset only touches core_reset
    user_rst = 1; tick();
    chk("ur_assert", 32'(core_reset), 32'd1);
    user_rst = 0; tick();
    chk("ur_release", 32'(core_reset), 32'd0);
    chk("ur_tno", 32'(tno), 32'd7);
    // system reset in the middle of a ROM load
    load_seq(8'd0, 1000, 0, 500);
    repeat (RH + 5) tick();
    chk("mid_loaded", 32'(loaded), 32'd0);
    chk("mid_tno", 32'(tno), 32'd0);
    chk("mid_crst", 32'(core_reset), 32'd1);
    // checksum of three bytes
    dl_bytes(8'd0, 3, 24'h1002FF);
    repeat (3) tick();
`ifdef LOAD_CHECKSUM_EN
    chk("checksum_lit", 32'(checksum), 32'h11);
`else
    chk("checksum_lit", 32'(checksum), 32'h00);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/druaga_load_ctrl.md
# druaga_load_ctrl

Sequences the HPS ROM/DIP download stream into the game core and owns the core's reset. It routes index-0 bytes to the core ROM write port and latches the title number (index 1) and DIP bytes (index 254). It also assembles the per-title 24-bit DSW word. The core is held in reset until a complete ROM image is present and a post-load settle time has elapsed. It sits between `hps_io` and `fpga_druaga`, replacing ad-hoc glue in `emu`.

## Interface
Parameters:
- `ROM_AW`, 17: width of `rom_addr` and of the byte counter (counter is `ROM_AW+1` bits).
- `ROM_SIZE`, 81920: bytes required for a valid index-0 image.
- `RST_HOLD`, 256: clk_sys cycles the core stays in reset after a valid load.

Ports:
- `clk_sys` in 1: single clock for all logic.
- `reset` in 1: synchronous, active-high.
- `user_rst` in 1: OSD/button reset request, level.
- `ioctl_download` in 1: download active.
- `ioctl_wr` in 1: byte strobe, 1 cycle.
- `ioctl_addr` in 25: byte address.
- `ioctl_dout` in 8: byte data.
- `ioctl_index` in 8: stream index; stable while `ioctl_download` is high.
- `rom_we` out 1: core ROM write strobe.
- `rom_addr` out ROM_AW: core ROM address.
- `rom_dout` out 8: core ROM data.
- `tno` out 4: title/model number.
- `dsw` out 24: {DSW2, DSW1, DSW0}.
- `core_reset` out 1: reset to game core.
- `loaded` out 1: a complete image is present.
- `overflow` out 1: sticky; an index-0 byte fell outside ROM_SIZE.
- `checksum` out 8: additive ROM checksum (see Configuration).

## Operation
FSM states: IDLE, LOAD, HOLD, RUN. All transitions occur on `clk_sys`.
- IDLE → LOAD: `ioctl_download`=1.
- LOAD → HOLD: `ioctl_download`=0 and `loaded`=1.
- LOAD → IDLE: `ioctl_download`=0 and `loaded`=0.
- HOLD → RUN: hold counter reaches RST_HOLD-1.
- HOLD → LOAD: `ioctl_download`=1. This takes priority over the counter.
- RUN → LOAD: `ioctl_download`=1.
- On entering LOAD with `ioctl_index`=0, the following are cleared: byte counter, `loaded`, `overflow`, and the checksum. Entering LOAD with any other index leaves them untouched, so a DIP-only download does not invalidate the ROM.

Writes are accepted only when `ioctl_wr`=1 and `ioctl_download`=1.
- Index 0, `ioctl_addr` < ROM_SIZE:
  - `rom_we`/`rom_addr`/`rom_dout` are driven from the registered inputs (`rom_addr` = `ioctl_addr[ROM_AW-1:0]`).
  - The counter increments, saturating at 2^(ROM_AW+1)-1.
- Index 0, `ioctl_addr` ≥ ROM_SIZE: the byte is dropped (no `rom_we`) and `overflow` is set.
- Index 1: `tno` ← `ioctl_dout[3:0]`. Last byte wins.
- Index 254 with `ioctl_addr[24:3]`=0: `sw[ioctl_addr[2:0]]` ← `ioctl_dout`. Only sw[0..2] feed `dsw`.
- Any other index is ignored.

`loaded` is set on the cycle the FSM leaves LOAD (for an index-0 load) if counter ≥ ROM_SIZE.

`core_reset` = `reset` | `user_rst` | (state ≠ RUN), registered.

`dsw` is combinational from the registered `tno` and sw[]:
- `tno` = 1 or 3: {sw1[3:0], sw2[3:0], sw1, sw0}.
- `tno` = 2: {sw2[3:0], sw2[3:0], sw1, sw0}.
- Otherwise: {sw2, sw1, sw0}.

Boundary behaviour:
- A write coincident with the `ioctl_download` fall is accepted and counted before the `loaded` evaluation.
- `reset` mid-download clears everything (state IDLE, counter 0, `loaded`=0, `tno`=0, sw[]=0). If `ioctl_download` is still high, LOAD is re-entered and counting restarts from 0; the resulting partial image leaves the FSM in IDLE.
- `user_rst` does not affect the FSM or the latches.

## Timing
- Reset values: `rom_we`=0, `rom_addr`=0, `rom_dout`=0, `tno`=0, sw[]=0 (so `dsw`=0), `core_reset`=1, `loaded`=0, `overflow`=0, `checksum`=0, state IDLE.
- `ioctl_wr` → `rom_we` latency: 1 cycle. `rom_we` is a 1-cycle pulse per accepted byte. Back-to-back strobes are supported.
- `tno` and sw[] update 1 cycle after the strobe.
- `core_reset`:
  - Deasserts RST_HOLD+2 cycles after the `ioctl_download` fall: 1 cycle into HOLD, RST_HOLD cycles in HOLD, plus the output register.
  - Asserts 2 cycles after the `ioctl_download` rise.
  - Asserts 1 cycle after `reset`/`user_rst`.

## Configuration
- `LOAD_CHECKSUM_EN` defined: `checksum` accumulates an 8-bit modulo-256 sum of every accepted index-0 byte, updated with `rom_we`. It is cleared on index-0 LOAD entry and on `reset`.
- `LOAD_CHECKSUM_EN` undefined: `checksum` is tied to 8'h00 and no adder is built.

## Test plan
- Full load, ROM_SIZE bytes at index 0, addresses 0..81919 → 81920 `rom_we` pulses, `loaded`=1, `core_reset` falls RST_HOLD+2 cycles after the download ends.
- Short load of 1000 bytes → FSM returns to IDLE, `loaded`=0, `core_reset` stays 1.
- Index-0 write at address 81920 → no `rom_we`, `overflow`=1. A later full index-0 load clears `overflow`.
- After a valid load: index-1 byte 8'h02 and index-254 bytes {sw0=8'hA5, sw1=8'h3C, sw2=8'h7E} → `tno`=2, `dsw`=24'hEE3CA5. The ROM is still `loaded`, and the FSM returns through HOLD to RUN.
- `reset` pulse at byte 500 of a running index-0 load, download continuing → counter restarts, `loaded`=0 at end, `tno`=0.
- With `LOAD_CHECKSUM_EN`: bytes 8'hFF, 8'h02, 8'h10 at index 0 → `checksum`=8'h11. Without it → `checksum`=8'h00.
